// File: rtl/ws2812_pkg.sv
// Shared state encoding, GRB word width and 50 MHz timing defaults for the
// WS2812 frame driver and its bit encoder.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } ws_state_e;

    localparam int GRB_WIDTH = 24;

    localparam int DEF_MAX_POS      = 109;
    localparam int DEF_BIT_CYCLES   = 62;
    localparam int DEF_T1H_CYCLES   = 40;
    localparam int DEF_T0H_CYCLES   = 20;
    localparam int DEF_LATCH_CYCLES = 15000;

    // $clog2(1) is 0, which would give a zero-width counter for a one-LED chain.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_frame_driver_if.sv
// Link between the screen manager (master) and the WS2812 frame driver (slave):
// frame request, LED index, GRB intensities and the strip-side outputs.
interface ws2812_frame_driver_if
    import ws2812_pkg::*;
#(
    parameter int MAX_POS = DEF_MAX_POS
);
    localparam int LED_W = cnt_width(MAX_POS);

    logic             start;
    logic [LED_W-1:0] led_number;
    logic [7:0]       i_red_intensity;
    logic [7:0]       i_green_intensity;
    logic [7:0]       i_blue_intensity;
    logic             dout;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, i_red_intensity, i_green_intensity, i_blue_intensity,
        input  led_number, dout, busy, frame_done
    );

    modport slave (
        input  start, i_red_intensity, i_green_intensity, i_blue_intensity,
        output led_number, dout, busy, frame_done
    );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// NRZ bit cell generator: a `go` strobe starts one BIT_CYCLES-long cell whose
// high phase is T1H_CYCLES or T0H_CYCLES; `bit_done` marks the cell's last clock.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic bit_value,
    output logic dout,
    output logic bit_done
);
    localparam int               CNT_W    = cnt_width(BIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             active;
    logic             bit_q;

    assign cnt_inc  = cnt + 1'b1;
    assign bit_done = active && (cnt == LAST_CNT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
            bit_q  <= 1'b0;
            dout   <= 1'b0;
        end else if (go) begin
            cnt    <= '0;
            active <= 1'b1;
            bit_q  <= bit_value;
            dout   <= (bit_value ? T1H : T0H) != '0;
        end else if (bit_done) begin
            cnt    <= '0;
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (active) begin
            cnt    <= cnt_inc;
            dout   <= cnt_inc < (bit_q ? T1H : T0H);
        end
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812 frame driver: walks led_number over the chain, captures GRB per LED and
// shifts it out MSB-first, then holds a latch gap. Build option WS_AUTO_REFRESH_EN
// makes the latch gap roll straight into the next frame.
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int MAX_POS      = DEF_MAX_POS,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    ws2812_frame_driver_if.slave        bus
);
    localparam int               LED_W      = cnt_width(MAX_POS);
    localparam int               LAT_W      = cnt_width(LATCH_CYCLES);
    localparam logic [LED_W-1:0] LED_LAST   = LED_W'(MAX_POS - 1);
    localparam logic [LAT_W-1:0] LATCH_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]       BIT_LAST   = 5'(GRB_WIDTH - 1);

    if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
        $error("ws2812_frame_driver: T0H_CYCLES < T1H_CYCLES < BIT_CYCLES violated");
    end
    if (MAX_POS < 1) begin : g_bad_max_pos
        $error("ws2812_frame_driver: MAX_POS must be at least 1");
    end

    ws_state_e            state, state_d;
    logic [GRB_WIDTH-1:0] shreg, shreg_d;
    logic [4:0]           bit_idx, bit_idx_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic [LAT_W-1:0]     lcnt, lcnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 go, go_bit, bit_done, enc_dout;

    ws2812_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .T0H_CYCLES (T0H_CYCLES)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .bit_value (go_bit),
        .dout      (enc_dout),
        .bit_done  (bit_done)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        led_d     = led_q;
        lcnt_d    = lcnt;
        go        = 1'b0;
        go_bit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = {bus.i_green_intensity, bus.i_red_intensity, bus.i_blue_intensity};
                bit_idx_d = '0;
                go        = 1'b1;
                go_bit    = bus.i_green_intensity[7];
                state_d   = SEND;
            end
            SEND: begin
                if (bit_done) begin
                    shreg_d = shreg << 1;
                    if (bit_idx == BIT_LAST) begin
                        if (led_q == LED_LAST) begin
                            lcnt_d  = '0;
                            state_d = LATCH;
                        end else begin
                            led_d   = led_q + 1'b1;
                            state_d = LOAD;
                        end
                    end else begin
                        // The next bit starts on the same edge, so bit cells abut.
                        bit_idx_d = bit_idx + 5'd1;
                        go        = 1'b1;
                        go_bit    = shreg[GRB_WIDTH-2];
                    end
                end
            end
            LATCH: begin
                if (lcnt == LATCH_LAST) begin
                    led_d  = '0;
                    lcnt_d = '0;
`ifdef WS_AUTO_REFRESH_EN
                    state_d = LOAD;
`else
                    state_d = IDLE;
`endif
                end else begin
                    lcnt_d = lcnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from next-state values to stay glitch-free.
        busy_d = (state_d != IDLE);
        done_d = (state_d == LATCH) && (lcnt_d == LATCH_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            led_q   <= '0;
            lcnt    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_idx <= bit_idx_d;
            led_q   <= led_d;
            lcnt    <= lcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.led_number = led_q;
    assign bus.dout       = enc_dout;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule
